// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state encodings and owner type shared by the memory port arbiter
package mem_port_arbiter_pkg;
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_REQ  = 2'd1;
    localparam arb_state_t ARB_RESP = 2'd2;
    typedef enum logic {OWNER_INSTR, OWNER_DATA} mem_owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one OBI memory port between fetch and load/store,
// data first with bounded fetch starvation, dropping flushed fetch responses
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    input  logic                instr_flush_i,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);
    localparam logic [3:0] MAX_S = 4'(MAX_DATA_STREAK);
    arb_state_t          state_q;
    mem_owner_t          owner_q;
    logic                we_q;
    logic [DATA_W/8-1:0] be_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          streak_q;
    logic                discard_q;
    logic                idle;
    logic                pick_instr;
    logic                resp_done;
    assign idle       = state_q == ARB_IDLE;
    // fetch wins when alone or once data has used up its streak
    assign pick_instr = instr_req_i && (!data_req_i || streak_q == MAX_S);
    assign instr_gnt_o = !rst_i && idle && pick_instr;
    assign data_gnt_o  = !rst_i && idle && data_req_i && !pick_instr;
    assign resp_done   = state_q == ARB_RESP && mem_rvalid_i;
    assign instr_rvalid_o = resp_done && owner_q == OWNER_INSTR && !discard_q && !instr_flush_i;
    assign data_rvalid_o  = resp_done && owner_q == OWNER_DATA;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign mem_req_o   = state_q == ARB_REQ;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = !idle;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_INSTR;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            streak_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            if (instr_gnt_o || data_gnt_o) begin
                state_q  <= ARB_REQ;
                owner_q  <= data_gnt_o ? OWNER_DATA : OWNER_INSTR;
                we_q     <= data_gnt_o && data_we_i;
                be_q     <= data_gnt_o ? data_be_i : '1;
                addr_q   <= data_gnt_o ? data_addr_i : instr_addr_i;
                wdata_q  <= data_gnt_o ? data_wdata_i : '0;
                streak_q <= (data_gnt_o && instr_req_i) ? (streak_q == MAX_S ? MAX_S : streak_q + 4'd1) : '0;
            end
            if (state_q == ARB_REQ && mem_gnt_i)
                state_q <= ARB_RESP;
            if (resp_done) begin
                state_q   <= ARB_IDLE;
                discard_q <= 1'b0;
            end else if (!idle && owner_q == OWNER_INSTR && instr_flush_i)
                discard_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus against a transaction-level model of the arbiter
module tb_mem_port_arbiter;
    localparam int MAX = 4;
    logic        clk_i = 0, rst_i;
    logic        instr_req_i, instr_flush_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int checks = 0, errors = 0;
    int gnt_wait, rv_wait, wcnt, rcnt;
    bit pend, stray, rst_s, rec_en;
    logic [31:0] rd_val;
    string gs;

    // model state: one transaction record plus a streak counter
    bit m_busy, m_acc, m_d, m_we, m_disc;
    logic [3:0] m_be;
    logic [31:0] m_addr, m_wdata;
    int m_streak;

    mem_port_arbiter #(.MAX_DATA_STREAK(MAX), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_flush_i(instr_flush_i),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy_o; i++) cyc();
        chk("idle_timeout", busy_o, 0);
    endtask

    task automatic wait_grants(input int n);
        for (int i = 0; i < 80 && gs.len() < n; i++) cyc();
    endtask

    task automatic chk_seq(input string nm, input string exp);
        checks++;
        if (gs != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", nm, gs, exp);
        end
    endtask

    function automatic logic [1:0] exp_grants();
        logic ig;
        ig = !rst_i && !m_busy && instr_req_i && (!data_req_i || m_streak == MAX);
        return {ig, !rst_i && !m_busy && data_req_i && !ig};
    endfunction

    // memory responder: gnt after gnt_wait REQ cycles, rvalid rv_wait cycles into RESP
    initial begin
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        forever begin
            @(posedge clk_i);
            rst_s = rst_i;
            #2;
            mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = rd_val;
            if (rst_s) begin
                pend = 0; wcnt = 0; rcnt = 0;
            end else if (mem_req_o) begin
                if (wcnt == gnt_wait) begin mem_gnt_i = 1; wcnt = 0; pend = 1; rcnt = 0; end
                else wcnt++;
            end else if (pend) begin
                if (rcnt == rv_wait) begin mem_rvalid_i = 1; pend = 0; end
                else rcnt++;
            end else if (stray)
                mem_rvalid_i = 1;
        end
    end

    always @(posedge clk_i) begin
        logic [1:0] g;
        bit was_busy;
        if (rst_i) begin
            m_busy = 0; m_acc = 0; m_d = 0; m_we = 0; m_disc = 0;
            m_be = 0; m_addr = 0; m_wdata = 0; m_streak = 0;
        end else begin
            g = exp_grants();
            was_busy = m_busy;
            if (g != 0) begin
                m_busy = 1; m_acc = 0; m_d = g[0];
                m_we = g[0] && data_we_i;
                m_be = g[0] ? data_be_i : 4'hf;
                m_addr = g[0] ? data_addr_i : instr_addr_i;
                m_wdata = data_wdata_i;
                m_streak = (g[0] && instr_req_i) ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
            end else if (m_busy && !m_acc && mem_gnt_i)
                m_acc = 1;
            else if (m_busy && m_acc && mem_rvalid_i) begin
                m_busy = 0; m_disc = 0;
            end
            if (was_busy && m_busy && !m_d && instr_flush_i) m_disc = 1;
        end
    end

    always @(negedge clk_i) begin
        logic [1:0] g;
        bit rv;
        g = exp_grants();
        rv = m_busy && m_acc && mem_rvalid_i;
        chk("instr_gnt", instr_gnt_o, g[1]);
        chk("data_gnt", data_gnt_o, g[0]);
        chk("busy", busy_o, m_busy);
        chk("mem_req", mem_req_o, m_busy && !m_acc);
        if (m_busy && !m_acc) begin
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_we", mem_we_o, m_we);
            chk("mem_be", mem_be_o, m_be);
            if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
        end
        chk("instr_rvalid", instr_rvalid_o, rv && !m_d && !m_disc && !instr_flush_i);
        chk("data_rvalid", data_rvalid_o, rv && m_d);
        chk("instr_rdata", instr_rdata_o, mem_rdata_i);
        chk("data_rdata", data_rdata_o, mem_rdata_i);
        if (rec_en && !rst_i && data_gnt_o) gs = {gs, "D"};
        if (rec_en && !rst_i && instr_gnt_o) gs = {gs, "I"};
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1; instr_req_i = 0; instr_addr_i = 0; instr_flush_i = 0;
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        gnt_wait = 0; rv_wait = 0; stray = 0; rec_en = 0; rd_val = 0; gs = "";
        repeat (3) cyc();
        #3;
        chk("rst_mem_req", mem_req_o, 0); chk("rst_busy", busy_o, 0);
        chk("rst_addr", mem_addr_o, 0); chk("rst_we", mem_we_o, 0); chk("rst_be", mem_be_o, 0);
        cyc(); rst_i = 0;
        // single fetch, zero-wait memory
        instr_req_i = 1; instr_addr_i = 32'h100; rd_val = 32'h00A00093;
        #3 chk("t1_igrant", instr_gnt_o, 1); chk("t1_dgnt", data_gnt_o, 0);
        cyc(); instr_req_i = 0;
        #3 chk("t1_req", mem_req_o, 1); chk("t1_addr", mem_addr_o, 32'h100); chk("t1_we", mem_we_o, 0);
        cyc();
        #3 chk("t1_rvalid", instr_rvalid_o, 1); chk("t1_rdata", instr_rdata_o, 32'h00A00093);
        chk("t1_drvalid", data_rvalid_o, 0);
        cyc();
        #3 chk("t1_idle", busy_o, 0);
        cyc();
        // store with three stalled gnt cycles
        gnt_wait = 3; data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011;
        data_addr_i = 32'h2004; data_wdata_i = 32'hDEADBEEF;
        #3 chk("t2_dgnt", data_gnt_o, 1);
        cyc(); data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        for (int i = 0; i < 4; i++) begin
            #3 chk("t2_req", mem_req_o, 1); chk("t2_addr", mem_addr_o, 32'h2004);
            chk("t2_wdata", mem_wdata_o, 32'hDEADBEEF); chk("t2_be", mem_be_o, 4'b0011); chk("t2_we", mem_we_o, 1);
            cyc();
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin #3 n += int'(data_rvalid_o); cyc(); end
        chk("t2_pulses", n, 1);
        gnt_wait = 0;
        // both requesters held: streak limit hands every fifth grant to fetch
        gs = ""; rec_en = 1;
        instr_req_i = 1; instr_addr_i = 32'h300; data_req_i = 1; data_we_i = 0; data_be_i = 4'hf; data_addr_i = 32'h400;
        wait_grants(10);
        rec_en = 0; instr_req_i = 0; data_req_i = 0;
        chk_seq("t3_seq", "DDDDIDDDDI");
        wait_idle();
        // flush in RESP discards the fetch response
        rv_wait = 2; instr_req_i = 1; instr_addr_i = 32'h200;
        #3 chk("t4_igrant", instr_gnt_o, 1);
        cyc(); instr_req_i = 0;
        cyc(); instr_flush_i = 1;
        cyc(); instr_flush_i = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin #3 n += int'(instr_rvalid_o); cyc(); end
        chk("t4_discard", n, 0);
        wait_idle();
        rv_wait = 0; instr_req_i = 1; instr_addr_i = 32'h204; rd_val = 32'h12345678;
        #3 chk("t4_igrant2", instr_gnt_o, 1);
        cyc(); instr_req_i = 0;
        cyc();
        #3 chk("t4_rvalid2", instr_rvalid_o, 1); chk("t4_rdata2", instr_rdata_o, 32'h12345678);
        cyc();
        // flush during a data transaction and stray rvalid in IDLE are ignored
        stray = 1; data_req_i = 1; data_addr_i = 32'h500; instr_flush_i = 1;
        #3 chk("t5_dgnt", data_gnt_o, 1);
        cyc(); data_req_i = 0;
        cyc();
        #3 chk("t5_drvalid", data_rvalid_o, 1);
        cyc(); instr_flush_i = 0;
        #3 chk("t5_stray_d", data_rvalid_o, 0); chk("t5_stray_i", instr_rvalid_o, 0); chk("t5_busy", busy_o, 0);
        stray = 0;
        cyc();
        // reset mid-transaction clears state and the data streak
        gnt_wait = 4; gs = ""; rec_en = 1;
        instr_req_i = 1; data_req_i = 1; data_addr_i = 32'h600;
        for (int i = 0; i < 40; i++) begin cyc(); #5; if (gs.len() == 2) break; end
        chk("t6_pre_grants", gs.len(), 2);
        cyc(); rst_i = 1; gnt_wait = 0;
        cyc();
        #2 chk("t6_req", mem_req_o, 0); chk("t6_busy", busy_o, 0);
        chk("t6_dgnt_rst", data_gnt_o, 0); chk("t6_igrant_rst", instr_gnt_o, 0);
        gs = ""; rst_i = 0;
        #1 chk("t6_dgnt", data_gnt_o, 1);
        wait_grants(5);
        rec_en = 0; instr_req_i = 0; data_req_i = 0;
        chk_seq("t6_seq", "DDDDI");
        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
